// File: rtl/axi_remap_pkg.sv
// Shared types and helpers for the AXI address remap slice: the field-copy
// remap function and the counter saturation constant.
package axi_remap_pkg;

    localparam int unsigned MAX_ADDR_W = 128;
    localparam int unsigned MAX_CNT_W  = 64;

    // Slice [CNT_W-1:0] of this for a saturated counter of any width up to MAX_CNT_W.
    localparam logic [MAX_CNT_W-1:0] CNT_SAT_ALL = '1;

    typedef logic [MAX_ADDR_W-1:0] addr_max_t;

    typedef struct packed {
        addr_max_t addr;
        logic      conflict;
    } remap_res_t;

    // Copies addr[src_lsb +: field_w] into addr[dst_lsb +: field_w] when en is set.
    // The conflict bit is raised when the overwritten destination field was nonzero.
    function automatic remap_res_t remap_addr(
        input addr_max_t   addr,
        input logic        en,
        input int unsigned field_w,
        input int unsigned src_lsb,
        input int unsigned dst_lsb,
        input logic        clear_src
    );
        remap_res_t res;
        addr_max_t  mask;
        addr_max_t  field;
        mask         = (addr_max_t'(1) << field_w) - addr_max_t'(1);
        field        = (addr >> src_lsb) & mask;
        res.conflict = en && (((addr >> dst_lsb) & mask) != '0);
        res.addr     = addr;
        if (en) begin
            res.addr = (addr & ~(mask << dst_lsb)) | (field << dst_lsb);
            if (clear_src) begin
                res.addr = res.addr & ~(mask << src_lsb);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi_addr_remap_chan.sv
// One AXI address channel: full-throughput two-entry skid slice with the
// address remap applied at acceptance, a sticky conflict flag and a saturating counter.
module axi_addr_remap_chan
    import axi_remap_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned PAYLOAD_W = 32,
    parameter int unsigned FIELD_W   = 5,
    parameter int unsigned SRC_LSB   = 16,
    parameter int unsigned DST_LSB   = 44,
    parameter bit          CLEAR_SRC = 1'b0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_en_i,
    input  logic                 stat_clr_i,
    input  logic [ADDR_W-1:0]    s_addr_i,
    input  logic [PAYLOAD_W-1:0] s_payload_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    output logic [ADDR_W-1:0]    m_addr_o,
    output logic [PAYLOAD_W-1:0] m_payload_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 conflict_o,
    output logic [CNT_W-1:0]     cnt_o
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_SAT_ALL[CNT_W-1:0];

    logic                 out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]    out_addr_q, out_addr_d;
    logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [ADDR_W-1:0]    skid_addr_q, skid_addr_d;
    logic [PAYLOAD_W-1:0] skid_payload_q, skid_payload_d;
    logic                 conflict_q, conflict_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    remap_res_t           remap;
    logic [ADDR_W-1:0]    remap_addr_w;
    logic                 unused_remap_hi;
    logic                 accept;
    logic                 drain;

    always_comb begin
        remap = remap_addr(addr_max_t'(s_addr_i), cfg_en_i, FIELD_W, SRC_LSB, DST_LSB, CLEAR_SRC);
    end

    assign remap_addr_w    = remap.addr[ADDR_W-1:0];
    assign unused_remap_hi = ^remap.addr[MAX_ADDR_W-1:ADDR_W];

    // s_ready is a pure register output, so upstream never sees a combinational path from m_ready.
    assign accept = s_valid_i & ~skid_valid_q;
    assign drain  = out_valid_q & m_ready_i;

    // NOTE: every next-state variable gets its hold value first, so no path leaves one unassigned (no latch).
    always_comb begin
        out_valid_d    = out_valid_q;
        out_addr_d     = out_addr_q;
        out_payload_d  = out_payload_q;
        skid_valid_d   = skid_valid_q;
        skid_addr_d    = skid_addr_q;
        skid_payload_d = skid_payload_q;
        cnt_d          = cnt_q;
        conflict_d     = conflict_q;

        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_valid_d   = 1'b1;
                out_addr_d    = skid_addr_q;
                out_payload_d = skid_payload_q;
                skid_valid_d  = 1'b0;
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_addr_d    = remap_addr_w;
                    out_payload_d = s_payload_i;
                end
            end
        end else if (accept) begin
            skid_valid_d   = 1'b1;
            skid_addr_d    = remap_addr_w;
            skid_payload_d = s_payload_i;
        end

        // Clear beats a simultaneous increment; a simultaneous conflict beats clear.
        if (stat_clr_i) begin
            cnt_d = '0;
        end else if (accept && cfg_en_i && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (accept && remap.conflict) begin
            conflict_d = 1'b1;
        end else if (stat_clr_i) begin
            conflict_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_addr_q    <= '0;
            out_payload_q <= '0;
            skid_valid_q  <= 1'b0;
            conflict_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_addr_q    <= out_addr_d;
            out_payload_q <= out_payload_d;
            skid_valid_q  <= skid_valid_d;
            conflict_q    <= conflict_d;
            cnt_q         <= cnt_d;
        end
    end

    // NOTE: skid data is deliberately not reset; skid_valid_q alone qualifies it.
    always_ff @(posedge clk) begin
        skid_addr_q    <= skid_addr_d;
        skid_payload_q <= skid_payload_d;
    end

    assign s_ready_o   = ~skid_valid_q;
    assign m_valid_o   = out_valid_q;
    assign m_addr_o    = out_addr_q;
    assign m_payload_o = out_payload_q;
    assign conflict_o  = conflict_q;
    assign cnt_o       = cnt_q;

endmodule

// File: rtl/axi_addr_remap_slice.sv
// Registered AW/AR address remapper: two independent remap channels sharing
// the enable and statistics-clear controls.
module axi_addr_remap_slice
    import axi_remap_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned PAYLOAD_W = 32,
    parameter int unsigned FIELD_W   = 5,
    parameter int unsigned SRC_LSB   = 16,
    parameter int unsigned DST_LSB   = 44,
    parameter bit          CLEAR_SRC = 1'b0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_en,
    input  logic                 stat_clr,
    input  logic [ADDR_W-1:0]    s_aw_addr,
    input  logic [PAYLOAD_W-1:0] s_aw_payload,
    input  logic                 s_aw_valid,
    output logic                 s_aw_ready,
    output logic [ADDR_W-1:0]    m_aw_addr,
    output logic [PAYLOAD_W-1:0] m_aw_payload,
    output logic                 m_aw_valid,
    input  logic                 m_aw_ready,
    input  logic [ADDR_W-1:0]    s_ar_addr,
    input  logic [PAYLOAD_W-1:0] s_ar_payload,
    input  logic                 s_ar_valid,
    output logic                 s_ar_ready,
    output logic [ADDR_W-1:0]    m_ar_addr,
    output logic [PAYLOAD_W-1:0] m_ar_payload,
    output logic                 m_ar_valid,
    input  logic                 m_ar_ready,
    output logic [1:0]           conflict,
    output logic [CNT_W-1:0]     aw_cnt,
    output logic [CNT_W-1:0]     ar_cnt
);

    if (FIELD_W == 0) begin : g_err_field_w
        $error("axi_addr_remap_slice: FIELD_W must be nonzero");
    end
    if ((SRC_LSB + FIELD_W > ADDR_W) || (DST_LSB + FIELD_W > ADDR_W)) begin : g_err_range
        $error("axi_addr_remap_slice: remap field exceeds ADDR_W");
    end
    if (!((SRC_LSB + FIELD_W <= DST_LSB) || (DST_LSB + FIELD_W <= SRC_LSB))) begin : g_err_overlap
        $error("axi_addr_remap_slice: source and destination fields overlap");
    end
    if ((ADDR_W >= MAX_ADDR_W) || (CNT_W == 0) || (CNT_W > MAX_CNT_W)) begin : g_err_width
        $error("axi_addr_remap_slice: ADDR_W or CNT_W outside supported range");
    end

    logic aw_conflict;
    logic ar_conflict;

    axi_addr_remap_chan #(
        .ADDR_W    (ADDR_W),
        .PAYLOAD_W (PAYLOAD_W),
        .FIELD_W   (FIELD_W),
        .SRC_LSB   (SRC_LSB),
        .DST_LSB   (DST_LSB),
        .CLEAR_SRC (CLEAR_SRC),
        .CNT_W     (CNT_W)
    ) u_aw (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_en_i    (cfg_en),
        .stat_clr_i  (stat_clr),
        .s_addr_i    (s_aw_addr),
        .s_payload_i (s_aw_payload),
        .s_valid_i   (s_aw_valid),
        .s_ready_o   (s_aw_ready),
        .m_addr_o    (m_aw_addr),
        .m_payload_o (m_aw_payload),
        .m_valid_o   (m_aw_valid),
        .m_ready_i   (m_aw_ready),
        .conflict_o  (aw_conflict),
        .cnt_o       (aw_cnt)
    );

    axi_addr_remap_chan #(
        .ADDR_W    (ADDR_W),
        .PAYLOAD_W (PAYLOAD_W),
        .FIELD_W   (FIELD_W),
        .SRC_LSB   (SRC_LSB),
        .DST_LSB   (DST_LSB),
        .CLEAR_SRC (CLEAR_SRC),
        .CNT_W     (CNT_W)
    ) u_ar (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_en_i    (cfg_en),
        .stat_clr_i  (stat_clr),
        .s_addr_i    (s_ar_addr),
        .s_payload_i (s_ar_payload),
        .s_valid_i   (s_ar_valid),
        .s_ready_o   (s_ar_ready),
        .m_addr_o    (m_ar_addr),
        .m_payload_o (m_ar_payload),
        .m_valid_o   (m_ar_valid),
        .m_ready_i   (m_ar_ready),
        .conflict_o  (ar_conflict),
        .cnt_o       (ar_cnt)
    );

    assign conflict = {ar_conflict, aw_conflict};

endmodule
